// File: rtl/stump_control_if.sv
// rtl/stump_control_if.sv - Stump control unit bus: memory/ALU inputs and decoded control outputs
interface stump_control_if;
   logic [15:0] data_in;
   logic [3:0]  alu_flags;
   logic        fetch;
   logic        execute;
   logic        memory;
   logic [15:0] ir;
   logic [2:0]  srcA;
   logic [2:0]  srcB;
   logic [2:0]  dest;
   logic        reg_write;
   logic        reg_data_sel;
   logic [2:0]  alu_func;
   logic [1:0]  opB_sel;
   logic        addr_sel;
   logic        addr_en;
   logic        mem_ren;
   logic        mem_wen;
   logic [3:0]  cc;

   modport master (
      input  data_in, alu_flags,
      output fetch, execute, memory, ir, srcA, srcB, dest, reg_write, reg_data_sel,
             alu_func, opB_sel, addr_sel, addr_en, mem_ren, mem_wen, cc
   );

   modport slave (
      output data_in, alu_flags,
      input  fetch, execute, memory, ir, srcA, srcB, dest, reg_write, reg_data_sel,
             alu_func, opB_sel, addr_sel, addr_en, mem_ren, mem_wen, cc
   );
endinterface

// File: rtl/stump_control.sv
// rtl/stump_control.sv - Stump fetch/execute/memory sequencer with IR and condition-code register
module stump_control (
   input  logic            clk,
   input  logic            rst,
   stump_control_if.master bus
);
   typedef enum logic [1:0] {FETCH = 2'b00, EXECUTE = 2'b01, MEMORY = 2'b10} state_t;

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic [3:0]  cc_q, cc_d;

   logic        fetch, execute, memory;
   logic [2:0]  src_a, src_b, dest, alu_func;
   logic        reg_write, reg_data_sel, addr_sel, addr_en, mem_ren, mem_wen;
   logic [1:0]  opb_sel;
   logic [2:0]  opcode;

   assign opcode = ir_q[15:13];

   // Flags are {N,Z,V,C}; branches only ever look at the registered copy.
   function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, v, c;
      {n, z, v, c} = f;
      case (cond)
         4'h0: cond_true = 1'b1;
         4'h1: cond_true = 1'b0;
         4'h2: cond_true = !c && !z;
         4'h3: cond_true = c || z;
         4'h4: cond_true = !c;
         4'h5: cond_true = c;
         4'h6: cond_true = !z;
         4'h7: cond_true = z;
         4'h8: cond_true = !v;
         4'h9: cond_true = v;
         4'hA: cond_true = !n;
         4'hB: cond_true = n;
         4'hC: cond_true = (n == v);
         4'hD: cond_true = (n != v);
         4'hE: cond_true = !z && (n == v);
         default: cond_true = z || (n != v);
      endcase
   endfunction

   always_comb begin
      state_d      = FETCH;
      ir_d         = ir_q;
      cc_d         = cc_q;
      fetch        = 1'b0;
      execute      = 1'b0;
      memory       = 1'b0;
      src_a        = 3'd0;
      src_b        = 3'd0;
      dest         = 3'd0;
      reg_write    = 1'b0;
      reg_data_sel = 1'b0;
      alu_func     = 3'd0;
      opb_sel      = 2'd0;
      addr_sel     = 1'b0;
      addr_en      = 1'b0;
      mem_ren      = 1'b0;
      mem_wen      = 1'b0;
      case (state_q)
         EXECUTE: begin
            execute = 1'b1;
            if (opcode == 3'd7) begin
               src_a     = 3'd7;
               opb_sel   = 2'd2;
               dest      = 3'd7;
               reg_write = cond_true(ir_q[11:8], cc_q);
            end else begin
               src_a   = ir_q[7:5];
               src_b   = ir_q[4:2];
               opb_sel = ir_q[12] ? 2'd1 : 2'd0;
               if (opcode == 3'd6) begin
                  addr_en = 1'b1;
                  state_d = MEMORY;
               end else begin
                  alu_func  = opcode;
                  dest      = ir_q[10:8];
                  reg_write = 1'b1;
                  if (ir_q[11]) cc_d = bus.alu_flags;
               end
            end
         end
         MEMORY: begin
            memory   = 1'b1;
            addr_sel = 1'b1;
            if (ir_q[11]) begin
               mem_wen = 1'b1;
               src_b   = ir_q[10:8];
            end else begin
               mem_ren      = 1'b1;
               dest         = ir_q[10:8];
               reg_data_sel = 1'b1;
               reg_write    = 1'b1;
            end
         end
         default: begin
            // Unused encoding behaves as FETCH so it recovers on the next edge.
            fetch     = 1'b1;
            src_a     = 3'd7;
            mem_ren   = 1'b1;
            opb_sel   = 2'd3;
            dest      = 3'd7;
            reg_write = 1'b1;
            ir_d      = bus.data_in;
            state_d   = EXECUTE;
         end
      endcase
      if (!rst) begin
         reg_write = 1'b0;
         mem_ren   = 1'b0;
         mem_wen   = 1'b0;
         addr_en   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= FETCH;
         ir_q    <= 16'd0;
         cc_q    <= 4'd0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cc_q    <= cc_d;
      end
   end

   assign bus.fetch        = fetch;
   assign bus.execute      = execute;
   assign bus.memory       = memory;
   assign bus.ir           = ir_q;
   assign bus.srcA         = src_a;
   assign bus.srcB         = src_b;
   assign bus.dest         = dest;
   assign bus.reg_write    = reg_write;
   assign bus.reg_data_sel = reg_data_sel;
   assign bus.alu_func     = alu_func;
   assign bus.opB_sel      = opb_sel;
   assign bus.addr_sel     = addr_sel;
   assign bus.addr_en      = addr_en;
   assign bus.mem_ren      = mem_ren;
   assign bus.mem_wen      = mem_wen;
   assign bus.cc           = cc_q;
endmodule

// File: tb/tb_stump_control.sv
// tb/tb_stump_control.sv - self-checking bench for stump_control against an instruction-level model
module tb_stump_control;
   logic clk;
   logic rst;
   stump_control_if bus ();

   stump_control dut (.clk(clk), .rst(rst), .bus(bus.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: which cycle of the current instruction we are in (0 fetch, 1 execute, 2 memory).
   int          m_phase;
   logic [15:0] m_ir;
   logic [3:0]  m_cc;

   function automatic logic model_branch(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, v, c, base;
      {n, z, v, c} = f;
      case (cond[3:1])
         3'd0: base = 1'b1;
         3'd1: base = !c && !z;
         3'd2: base = !c;
         3'd3: base = !z;
         3'd4: base = !v;
         3'd5: base = !n;
         3'd6: base = (n == v);
         default: base = !z && (n == v);
      endcase
      return cond[0] ? !base : base;
   endfunction

   // {fetch,execute,memory,srcA,srcB,dest,reg_write,reg_data_sel,alu_func,opB_sel,addr_sel,addr_en,mem_ren,mem_wen}
   function automatic logic [22:0] model_out(input logic rst_v);
      logic f, e, m, rw, rds, as, ae, mr, mw;
      logic [2:0] sa, sb, d, af;
      logic [1:0] ob;
      logic [2:0] op;
      op = m_ir[15:13];
      {f, e, m, rw, rds, as, ae, mr, mw} = '0;
      sa = 0; sb = 0; d = 0; af = 0; ob = 0;
      if (m_phase == 0) begin
         f = 1; sa = 7; mr = 1; ob = 3; d = 7; rw = 1;
      end else if (m_phase == 1) begin
         e = 1;
         if (op == 3'd7) begin
            sa = 7; ob = 2; d = 7; rw = model_branch(m_ir[11:8], m_cc);
         end else begin
            sa = m_ir[7:5]; sb = m_ir[4:2]; ob = m_ir[12] ? 2'd1 : 2'd0;
            if (op == 3'd6) ae = 1;
            else begin af = op; d = m_ir[10:8]; rw = 1; end
         end
      end else begin
         m = 1; as = 1;
         if (m_ir[11]) begin mw = 1; sb = m_ir[10:8]; end
         else begin mr = 1; d = m_ir[10:8]; rds = 1; rw = 1; end
      end
      if (!rst_v) begin rw = 0; mr = 0; mw = 0; ae = 0; end
      return {f, e, m, sa, sb, d, rw, rds, af, ob, as, ae, mr, mw};
   endfunction

   function automatic logic [22:0] dut_out();
      return {bus.fetch, bus.execute, bus.memory, bus.srcA, bus.srcB, bus.dest,
              bus.reg_write, bus.reg_data_sel, bus.alu_func, bus.opB_sel,
              bus.addr_sel, bus.addr_en, bus.mem_ren, bus.mem_wen};
   endfunction

   task automatic run_cycle(input logic [15:0] din, input logic [3:0] fl, input logic rv);
      logic [22:0] exp_v;
      logic [22:0] obs_v;
      @(negedge clk);
      bus.data_in   = din;
      bus.alu_flags = fl;
      rst           = rv;
      #1;
      exp_v = model_out(rv);
      obs_v = dut_out();
      checks++;
      assert (obs_v === exp_v) else begin
         errors++;
         $error("FAIL ctrl phase=%0d ir=%h observed=%h expected=%h", m_phase, m_ir, obs_v, exp_v);
      end
      checks++;
      assert (bus.ir === m_ir) else begin
         errors++;
         $error("FAIL ir observed=%h expected=%h", bus.ir, m_ir);
      end
      checks++;
      assert (bus.cc === m_cc) else begin
         errors++;
         $error("FAIL cc observed=%h expected=%h", bus.cc, m_cc);
      end
      @(posedge clk);
      if (!rv) begin
         m_phase = 0; m_ir = 16'd0; m_cc = 4'd0;
      end else if (m_phase == 0) begin
         m_ir = din; m_phase = 1;
      end else if (m_phase == 1) begin
         if (m_ir[15:13] == 3'd6) m_phase = 2;
         else begin
            if (m_ir[15:13] != 3'd7 && m_ir[11]) m_cc = fl;
            m_phase = 0;
         end
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic run_instr(input logic [15:0] instr, input logic [3:0] fl);
      run_cycle(instr, fl, 1'b1);
      for (int k = 0; k < 3 && m_phase != 0; k++) run_cycle(16'($urandom), fl, 1'b1);
   endtask

   initial begin
      rst = 1'b0;
      bus.data_in = 16'hFFFF;
      bus.alu_flags = 4'd0;
      repeat (2) @(posedge clk);
      m_phase = 0; m_ir = 16'd0; m_cc = 4'd0;
      run_cycle(16'hFFFF, 4'd0, 1'b0);

      run_instr(16'h0868, 4'b0100);
      run_instr(16'hF705, 4'b0000);
      run_instr(16'h0868, 4'b0000);
      run_instr(16'hF705, 4'b0100);
      run_instr(16'hD4A3, 4'b1111);
      run_instr(16'hDA20, 4'b1010);
      run_instr(16'hD8A3, 4'b1111);

      run_cycle(16'hDA20, 4'd0, 1'b1);
      run_cycle(16'h0000, 4'd0, 1'b1);
      run_cycle(16'h1234, 4'd0, 1'b0);
      run_cycle(16'h0868, 4'b1001, 1'b1);
      run_cycle(16'h0000, 4'b1001, 1'b1);

      for (int i = 0; i < 600; i++) begin
         run_cycle(16'($urandom), 4'($urandom), ($urandom_range(0, 39) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
